lsu_mem_stage: RTL

- Load/store unit directly downstream of the ALU.
- Consumes the ALU result as the effective address and rs2 as store data.
- Issues one word-aligned request on a valid/grant/rvalid data-memory port, then returns aligned, sign- or zero-extended load data to writeback.
- Stalls the core while an access is outstanding; single outstanding access only.

---
 rtl/singlecycle_pkg.sv | 55 +++++
 rtl/lsu_load_extend.sv | 26 ++
 rtl/lsu_mem_stage.sv | 113 +++++++++++
 3 files changed

// File: rtl/singlecycle_pkg.sv
// Shared LSU types and the address/size helpers used to build memory requests.
package singlecycle_pkg;

  typedef enum logic [2:0] {
    LSU_LB  = 3'b000,
    LSU_LH  = 3'b001,
    LSU_LW  = 3'b010,
    LSU_LBU = 3'b100,
    LSU_LHU = 3'b101
  } LsuSize_e;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT,
    LSU_DONE,
    LSU_ERR
  } LsuState_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_req_t;

  // Stores have no unsigned variants, so size[2] is illegal for them.
  function automatic logic lsu_fault(input logic we, input logic [2:0] size,
                                     input logic [1:0] off);
    logic illegal;
    illegal = (size == 3'b011) || (size[2:1] == 2'b11) || (we && size[2]);
    case (size[1:0])
      2'b01:   return illegal || off[0];
      2'b10:   return illegal || (off != 2'b00);
      default: return illegal;
    endcase
  endfunction

  function automatic logic [3:0] lsu_be(input logic [2:0] size, input logic [1:0] off);
    case (size[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lsu_wdata(input logic [2:0] size, input logic [31:0] wdata);
    case (size[1:0])
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module lsu_load_extend
  import singlecycle_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sx;

  always_comb begin
    byte_v = rdata[{off, 3'b000} +: 8];
    half_v = rdata[{off[1], 4'b0000} +: 16];
    sx     = ~size[2];
    case (size[1:0])
      2'b00:   result = {{24{sx & byte_v[7]}}, byte_v};
      2'b01:   result = {{16{sx & half_v[15]}}, half_v};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store stage: one outstanding word-aligned access on a req/gnt/rvalid port,
// with alignment/size fault detection and an optional REQ/WAIT timeout.
module lsu_mem_stage
  import singlecycle_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_lsu_valid,
  input  logic        i_lsu_we,
  input  logic [2:0]  i_lsu_size,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdata,
  output logic        o_lsu_ready,
  output logic        o_lsu_stall,
  output logic        o_lsu_rvalid,
  output logic [31:0] o_lsu_rdata,
  output logic        o_lsu_err,
  output logic        o_mem_req,
  input  logic        i_mem_gnt,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  localparam int CW = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(WAIT_TIMEOUT);

  LsuState_e   state_q, state_d;
  mem_req_t    mem_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]  size_q;
  logic [1:0]  off_q;
  logic [31:0] ext;
  logic        fault, timeout;

  assign fault   = lsu_fault(i_lsu_we, i_lsu_size, i_lsu_addr[1:0]);
  assign timeout = (WAIT_TIMEOUT != 0) && (cnt_q == TO_VAL);

  lsu_load_extend u_ext (
    .rdata  (i_mem_rdata),
    .off    (off_q),
    .size   (size_q),
    .result (ext)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= LSU_IDLE;
    else       state_q <= state_d;
  end

  // Grant/response take priority over a timeout landing in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (i_lsu_valid) state_d = fault ? LSU_ERR : LSU_REQ;
      LSU_REQ:  if (i_mem_gnt) state_d = LSU_WAIT;
                else if (timeout) state_d = LSU_ERR;
      LSU_WAIT: if (i_mem_rvalid) state_d = LSU_DONE;
                else if (timeout) state_d = LSU_ERR;
      LSU_DONE: state_d = LSU_IDLE;
      LSU_ERR:  state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_comb begin
    o_lsu_ready  = (state_q == LSU_IDLE);
    o_mem_req    = (state_q == LSU_REQ);
    o_lsu_rvalid = (state_q == LSU_DONE);
    o_lsu_err    = (state_q == LSU_ERR);
    o_lsu_stall  = ((state_q == LSU_IDLE) && i_lsu_valid) ||
                   (state_q == LSU_REQ) || (state_q == LSU_WAIT);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mem_q       <= '0;
      cnt_q       <= '0;
      size_q      <= '0;
      off_q       <= '0;
      o_lsu_rdata <= '0;
    end else begin
      case (state_q)
        LSU_IDLE: if (i_lsu_valid && !fault) begin
          mem_q.addr  <= {i_lsu_addr[31:2], 2'b00};
          mem_q.we    <= i_lsu_we;
          mem_q.be    <= lsu_be(i_lsu_size, i_lsu_addr[1:0]);
          mem_q.wdata <= lsu_wdata(i_lsu_size, i_lsu_wdata);
          size_q      <= i_lsu_size;
          off_q       <= i_lsu_addr[1:0];
          cnt_q       <= '0;
        end
        LSU_REQ:  cnt_q <= i_mem_gnt ? '0 : cnt_q + 1'b1;
        LSU_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (i_mem_rvalid && !mem_q.we) o_lsu_rdata <= ext;
        end
        default: ;
      endcase
    end
  end

  assign o_mem_addr  = mem_q.addr;
  assign o_mem_we    = mem_q.we;
  assign o_mem_be    = mem_q.be;
  assign o_mem_wdata = mem_q.wdata;

endmodule
